// File: rtl/sinegen_sweep_ctrl.sv
// Sweeps sinegen incr from start to stop in dwell-timed steps, advancing phase_offset each step; one-shot or ping-pong.
// All outputs registered, one cycle after start/abort/step boundary; no backpressure, abort always wins.
module sinegen_sweep_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DWELL_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode,
    input  logic [DATA_WIDTH-1:0]    incr_start,
    input  logic [DATA_WIDTH-1:0]    incr_stop,
    input  logic [DATA_WIDTH-1:0]    incr_step,
    input  logic [DWELL_WIDTH-1:0]   dwell,
    input  logic [ADDRESS_WIDTH-1:0] phase_step,
    output logic                     en_out,
    output logic [DATA_WIDTH-1:0]    incr,
    output logic [ADDRESS_WIDTH-1:0] phase_offset,
    output logic                     busy,
    output logic                     done,
    output logic                     step_tick
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  STEP_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic                     en_q, en_d, busy_q, busy_d, done_q, done_d, tick_q, tick_d;
    logic [DATA_WIDTH-1:0]    incr_q, incr_d, target_q, target_d;
    logic [ADDRESS_WIDTH-1:0] phase_q, phase_d;
    logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     dir_up_q, dir_up_d;
    logic [DATA_WIDTH-1:0]    start_sh_q, start_sh_d, stop_sh_q, stop_sh_d, step_sh_q, step_sh_d;
    logic [DWELL_WIDTH-1:0]   dwell_sh_q, dwell_sh_d;
    logic [ADDRESS_WIDTH-1:0] pstep_sh_q, pstep_sh_d;
    logic                     mode_sh_q, mode_sh_d;

    logic                     reach, boundary, flip, dir_use;
    logic [DATA_WIDTH-1:0]    tgt_use, stepped;
    logic [DATA_WIDTH:0]      sum_w, diff_w;

    assign reach    = (incr_q == target_q);
    assign boundary = (cnt_q == dwell_sh_q - DWELL_ONE);
    assign flip     = reach & mode_sh_q;
    // On a ping-pong reversal the step is taken toward the swapped target with the new direction.
    assign dir_use  = flip ? ~dir_up_q : dir_up_q;
    assign tgt_use  = flip ? ((target_q == stop_sh_q) ? start_sh_q : stop_sh_q) : target_q;
    assign sum_w    = {1'b0, incr_q} + {1'b0, step_sh_q};
    assign diff_w   = {1'b0, incr_q} - {1'b0, step_sh_q};

    always_comb begin
        stepped = tgt_use;
        if (dir_use) begin
            if (sum_w <= {1'b0, tgt_use}) stepped = sum_w[DATA_WIDTH-1:0];
        end else begin
            if (!diff_w[DATA_WIDTH] && (diff_w[DATA_WIDTH-1:0] >= tgt_use)) stepped = diff_w[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        tick_d     = 1'b0;
        incr_d     = incr_q;
        target_d   = target_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        dir_up_d   = dir_up_q;
        start_sh_d = start_sh_q;
        stop_sh_d  = stop_sh_q;
        step_sh_d  = step_sh_q;
        dwell_sh_d = dwell_sh_q;
        pstep_sh_d = pstep_sh_q;
        mode_sh_d  = mode_sh_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_sh_d = incr_start;
                    stop_sh_d  = incr_stop;
                    step_sh_d  = (incr_step == '0) ? STEP_ONE : incr_step;
                    dwell_sh_d = (dwell == '0) ? DWELL_ONE : dwell;
                    pstep_sh_d = phase_step;
                    mode_sh_d  = mode;
                    state_d    = S_RUN;
                    en_d       = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    incr_d     = incr_start;
                    target_d   = incr_stop;
                    dir_up_d   = (incr_start <= incr_stop);
                    phase_d    = '0;
                    cnt_d      = '0;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    phase_d = phase_q + pstep_sh_q;
                    if (reach && !mode_sh_q) begin
                        state_d = S_DONE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        incr_d   = stepped;
                        target_d = tgt_use;
                        dir_up_d = dir_use;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            en_d     = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            tick_d   = 1'b0;
            incr_d   = '0;
            phase_d  = '0;
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
            incr_q     <= '0;
            target_q   <= '0;
            phase_q    <= '0;
            cnt_q      <= '0;
            dir_up_q   <= 1'b1;
            start_sh_q <= '0;
            stop_sh_q  <= '0;
            step_sh_q  <= STEP_ONE;
            dwell_sh_q <= DWELL_ONE;
            pstep_sh_q <= '0;
            mode_sh_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
            incr_q     <= incr_d;
            target_q   <= target_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            dir_up_q   <= dir_up_d;
            start_sh_q <= start_sh_d;
            stop_sh_q  <= stop_sh_d;
            step_sh_q  <= step_sh_d;
            dwell_sh_q <= dwell_sh_d;
            pstep_sh_q <= pstep_sh_d;
            mode_sh_q  <= mode_sh_d;
        end
    end

    assign en_out       = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign step_tick    = tick_q;
    assign incr         = incr_q;
    assign phase_offset = phase_q;

endmodule

// File: doc/sinegen_sweep_ctrl.md
Name: sinegen_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the en, incr and phase_offset inputs of the sinegen block. On a start pulse it walks incr from a start value to a stop value in fixed steps, holding each step for a programmable dwell. Each step also advances the phase offset between the two sine outputs. Runs one-shot or ping-pong, and sits between the top-level control registers/switches and sinegen.

Parameters:
DATA_WIDTH, 8, width of incr values (matches sinegen DATA_WIDTH)
ADDRESS_WIDTH, 8, width of phase_offset (matches sinegen ADDRESS_WIDTH)
DWELL_WIDTH, 16, width of dwell counter/config

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  stop sweep; priority over start
mode  in  1  0 = one-shot, 1 = ping-pong
incr_start  in  DATA_WIDTH  first incr value
incr_stop  in  DATA_WIDTH  final incr value
incr_step  in  DATA_WIDTH  magnitude of incr change per step
dwell  in  DWELL_WIDTH  cycles per step
phase_step  in  ADDRESS_WIDTH  phase_offset increment per step
en_out  out  1  to sinegen en
incr  out  DATA_WIDTH  to sinegen incr
phase_offset  out  ADDRESS_WIDTH  to sinegen phase_offset
busy  out  1  high in RUN
done  out  1  high in DONE
step_tick  out  1  one-cycle pulse on each step

Behaviour:
- Reset (async, any time): state IDLE. en_out=0, incr=0, phase_offset=0, busy=0, done=0, step_tick=0, dwell_cnt=0, dir=up.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE + start (no abort): latch all config inputs into shadow registers. Next cycle: RUN, en_out=1, busy=1, done=0, incr=incr_start, phase_offset=0, dwell_cnt=0.
- dir: up if incr_start <= incr_stop, else down. The sweep target is incr_stop.
- Config changes after latch are ignored until the next start.
- Effective dwell is dwell, or 1 if dwell==0. Effective step is incr_step, or 1 if incr_step==0.
- RUN: dwell_cnt increments each cycle. When dwell_cnt == eff_dwell-1, that cycle is a step boundary:
  - dwell_cnt returns to 0.
  - step_tick=1 for the next cycle only.
  - phase_offset += phase_step, modulo 2^ADDRESS_WIDTH (wraps).
  - Endpoint check: if incr == target (the current incr already equals it), take the endpoint action:
    - one-shot: go to DONE.
    - ping-pong: reverse dir and swap target between the latched start and stop. incr then moves by one step toward the new target, clamped.
  - Otherwise incr steps toward target by eff_step. The sum/difference is computed in DATA_WIDTH+1 bits. The result is clamped to target if it would pass target, overflow above 2^DATA_WIDTH-1, or underflow below 0. incr therefore never wraps.
- Consequence: each incr value, including the endpoint, is held for exactly eff_dwell cycles.
- Degenerate case, incr_start == incr_stop: one-shot goes to DONE after one dwell. Ping-pong holds incr constant indefinitely while still ticking phase.
- DONE: en_out=0, busy=0, done=1 (held). incr and phase_offset keep their last values. step_tick is 0 except for the final pulse.
- abort (any state, synchronous): next cycle IDLE, en_out=0, incr=0, phase_offset=0, busy=0, done=0, dwell_cnt=0. abort with start in the same cycle gives IDLE.
- start while in RUN is ignored.
- Reset asserted mid-RUN immediately forces reset values. After deassertion the block stays in IDLE until start.

Test Plan:
- Reset: hold rst mid-sweep -> all outputs 0 asynchronously, before the next clk edge. Release -> IDLE, en_out=0.
- One-shot up: start=5, stop=20, step=5, dwell=3, phase_step=16.
  - incr is 5,10,15,20, each held 3 cycles.
  - step_tick pulses at each of the 4 boundaries.
  - phase_offset is 16,32,48,64.
  - After the 4th boundary: done=1, en_out=0, incr=20.
- Clamp/down: start=250, stop=3, step=100, dwell=1 -> incr is 250,150,50,3, then DONE. Never wraps. With start=3, stop=250 -> 3,103,203,250.
- Ping-pong: start=10, stop=30, step=10, dwell=2 -> incr is 10,20,30,20,10,20,... each held 2 cycles. Never reaches DONE. phase_offset wraps 240->0 with phase_step=16.
- Degenerate config:
  - dwell=0, step=0, start=0, stop=2 -> behaves as dwell=1, step=1: incr is 0,1,2, then DONE.
  - start=stop=7 in one-shot -> DONE after one dwell.
- abort/start interaction:
  - abort during RUN -> IDLE next cycle with incr=0, phase_offset=0.
  - abort and start in the same cycle -> IDLE.
  - Changing incr_stop during RUN has no effect.
  - start in DONE restarts from the new latched incr_start.
